// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: owns the CSR file ports, sequences trap entry / MRET writes and the PC redirect.
// Optional TRAP_VECTORED_EN enables mtvec vectored mode for interrupts.
module csr_trap_sequencer #(
  parameter int XLEN        = 32,
  parameter int IDX_W       = 4,
  parameter int MSTATUS_IDX = 0,
  parameter int MTVEC_IDX   = 2,
  parameter int MEPC_IDX    = 3,
  parameter int MCAUSE_IDX  = 4,
  parameter int MTVAL_IDX   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trapValid,
  input  logic [XLEN-1:0]  trapCause,
  input  logic [XLEN-1:0]  trapPc,
  input  logic [XLEN-1:0]  trapValue,
  input  logic             mretValid,
  output logic             trapAccept,
  input  logic             pipeCsrWe,
  input  logic [IDX_W-1:0] pipeCsrWrIdx,
  input  logic [XLEN-1:0]  pipeCsrWrData,
  input  logic [IDX_W-1:0] pipeCsrRdIdx,
  output logic             pipeCsrStall,
  output logic             csrDestinationEnable,
  output logic [IDX_W-1:0] destinationCSR,
  output logic [XLEN-1:0]  csrWriteData,
  output logic [IDX_W-1:0] readCSR,
  input  logic [XLEN-1:0]  csrReadData,
  output logic             redirectValid,
  output logic [XLEN-1:0]  redirectPc,
  output logic             busy
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] T_EPC    = 3'd1;
  localparam logic [2:0] T_CAUSE  = 3'd2;
  localparam logic [2:0] T_TVAL   = 3'd3;
  localparam logic [2:0] T_STATUS = 3'd4;
  localparam logic [2:0] T_REDIR  = 3'd5;
  localparam logic [2:0] R_STATUS = 3'd6;
  localparam logic [2:0] R_REDIR  = 3'd7;
  logic [2:0]      r_state, w_next;
  logic [XLEN-3:0] r_epc;
  logic [XLEN-1:0] r_cause, r_tval, w_base, w_tvec, w_status;
  logic            w_idle, w_take_trap, w_take_mret;
  assign w_idle       = r_state == IDLE;
  assign w_take_trap  = w_idle && trapValid && !reset;
  assign w_take_mret  = w_idle && mretValid && !trapValid && !reset;
  assign trapAccept   = w_take_trap || w_take_mret;
  assign busy         = !w_idle;
  assign pipeCsrStall = !w_idle;
  assign w_base       = {csrReadData[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign w_tvec = (csrReadData[1:0] == 2'b01 && r_cause[XLEN-1]) ? w_base + {r_cause[XLEN-3:0], 2'b00} : w_base;
`else
  assign w_tvec = w_base;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_epc   <= '0;
      r_cause <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_next;
      if (w_take_trap) begin
        r_epc   <= trapPc[XLEN-1:2];
        r_cause <= trapCause;
        r_tval  <= trapValue;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_take_trap ? T_EPC : w_take_mret ? R_STATUS : IDLE;
      T_EPC:    w_next = T_CAUSE;
      T_CAUSE:  w_next = T_TVAL;
      T_TVAL:   w_next = T_STATUS;
      T_STATUS: w_next = T_REDIR;
      R_STATUS: w_next = R_REDIR;
      default:  w_next = IDLE;
    endcase
  end
  // Reset suppresses any write/redirect in the cycle it is asserted.
  always_comb begin
    csrDestinationEnable = 1'b0;
    destinationCSR       = pipeCsrWrIdx;
    csrWriteData         = pipeCsrWrData;
    readCSR              = pipeCsrRdIdx;
    redirectValid        = 1'b0;
    redirectPc           = '0;
    w_status             = csrReadData;
    case (r_state)
      IDLE: csrDestinationEnable = pipeCsrWe;
      T_EPC: begin
        csrDestinationEnable = 1'b1;
        destinationCSR       = IDX_W'(MEPC_IDX);
        csrWriteData         = {r_epc, 2'b00};
      end
      T_CAUSE: begin
        csrDestinationEnable = 1'b1;
        destinationCSR       = IDX_W'(MCAUSE_IDX);
        csrWriteData         = r_cause;
      end
      T_TVAL: begin
        csrDestinationEnable = 1'b1;
        destinationCSR       = IDX_W'(MTVAL_IDX);
        csrWriteData         = r_tval;
      end
      T_STATUS: begin
        readCSR              = IDX_W'(MSTATUS_IDX);
        w_status[7]          = csrReadData[3];
        w_status[3]          = 1'b0;
        w_status[12:11]      = 2'b11;
        csrDestinationEnable = 1'b1;
        destinationCSR       = IDX_W'(MSTATUS_IDX);
        csrWriteData         = w_status;
      end
      T_REDIR: begin
        readCSR       = IDX_W'(MTVEC_IDX);
        redirectValid = 1'b1;
        redirectPc    = w_tvec;
      end
      R_STATUS: begin
        readCSR              = IDX_W'(MSTATUS_IDX);
        w_status[3]          = csrReadData[7];
        w_status[7]          = 1'b1;
        w_status[12:11]      = 2'b11;
        csrDestinationEnable = 1'b1;
        destinationCSR       = IDX_W'(MSTATUS_IDX);
        csrWriteData         = w_status;
      end
      default: begin
        readCSR       = IDX_W'(MEPC_IDX);
        redirectValid = 1'b1;
        redirectPc    = w_base;
      end
    endcase
    if (reset) begin
      csrDestinationEnable = 1'b0;
      redirectValid        = 1'b0;
    end
  end
endmodule
